// File: rtl/tft_pkg.sv
// Shared RGB565 colour constants and channel colour lookup for the waveform render path.
package tft_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t BLACK  = 16'h0000;
  localparam rgb565_t WHITE  = 16'hFFFF;
  localparam rgb565_t YELLOW = 16'hFFE0;
  localparam rgb565_t CYAN   = 16'h07FF;
  localparam rgb565_t PURPLE = 16'hF81F;
  localparam rgb565_t GREEN  = 16'h07E0;

  localparam rgb565_t GRID_COLOR = 16'h4208;
  localparam rgb565_t BG_COLOR   = BLACK;

  localparam rgb565_t CH_COLOR [4] = '{YELLOW, CYAN, PURPLE, GREEN};

  function automatic rgb565_t ch_color(input int unsigned idx);
    logic [1:0] sel;
    sel = idx[1:0];
    return CH_COLOR[sel];
  endfunction

endpackage

// File: rtl/tft_wave_render_if.sv
// Pixel request / frame-buffer read / pixel output bundle between TFT driver, RAM and renderer.
interface tft_wave_render_if #(
  parameter int unsigned CH_NUM = 2
);
  logic              tft_req;
  logic [10:0]       hcount;
  logic [10:0]       vcount;
  logic [CH_NUM-1:0] ch_en;
  logic [CH_NUM-1:0] data_in;
  logic [18:0]       addr;
  logic              rden;
  logic [15:0]       display_data;

  modport master (
    output tft_req, hcount, vcount, ch_en, data_in,
    input  addr, rden, display_data
  );

  modport slave (
    input  tft_req, hcount, vcount, ch_en, data_in,
    output addr, rden, display_data
  );
endinterface

// File: rtl/tft_line_addr.sv
// Multiplier-free frame-buffer address: per-line base accumulator plus registered read address.
module tft_line_addr #(
  parameter int unsigned H_ACTIVE = 800
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [10:0] hcount_i,
  input  logic [10:0] vcount_i,
  output logic [18:0] addr_o
);

  logic [18:0] base_q, base_d;
  logic [10:0] vcount_q;
  logic [18:0] addr_q, addr_d;

  // Valid only while the driver steps vcount by 0/+1 or wraps to 0.
  always_comb begin
    base_d = base_q;
    if (vcount_i == '0) begin
      base_d = '0;
    end else if (vcount_i != vcount_q) begin
      base_d = base_q + 19'(H_ACTIVE);
    end
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_d + {8'd0, hcount_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q   <= '0;
      vcount_q <= '0;
      addr_q   <= '0;
    end else begin
      base_q   <= base_d;
      vcount_q <= vcount_i;
      addr_q   <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/tft_wave_render.sv
// Waveform pixel renderer: frame-buffer read, latency-aligned valid pipe, priority colour mux.
// Define TFT_WAVE_GRID_EN to build the graticule grid counters.
module tft_wave_render
  import tft_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CH_NUM   = 2,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned GRID_X   = 50,
  parameter int unsigned GRID_Y   = 48
) (
  input logic           clk_vga,
  input logic           rst_n,
  tft_wave_render_if.slave bus
);

  if (CH_NUM < 1 || CH_NUM > 4 || RD_LAT < 1 || RD_LAT > 4 || GRID_X < 1 || GRID_Y < 1)
  begin : g_bad_cfg
    $error("tft_wave_render: unsupported parameter set");
  end

  logic        in_range;
  logic [18:0] addr;
  logic        grid_hit;

  assign in_range = bus.tft_req && (bus.hcount < 11'(H_ACTIVE)) && (bus.vcount < 11'(V_ACTIVE));

  tft_line_addr #(
    .H_ACTIVE (H_ACTIVE)
  ) u_line_addr (
    .clk_i    (clk_vga),
    .rst_ni   (rst_n),
    .load_i   (in_range),
    .hcount_i (bus.hcount),
    .vcount_i (bus.vcount),
    .addr_o   (addr)
  );

`ifdef TFT_WAVE_GRID_EN
  localparam int unsigned GxW = $clog2(GRID_X + 1);
  localparam int unsigned GyW = $clog2(GRID_Y + 1);

  logic [GxW-1:0] gx_q, gx_d;
  logic [GyW-1:0] gy_q, gy_d;
  logic [10:0]    gvc_q;

  // Modulo counters stand in for hcount % GRID_X and vcount % GRID_Y.
  always_comb begin
    gx_d = '0;
    if (bus.hcount != '0) begin
      gx_d = (gx_q == GxW'(GRID_X - 1)) ? '0 : gx_q + 1'b1;
    end
    gy_d = gy_q;
    if (bus.vcount == '0) begin
      gy_d = '0;
    end else if (bus.vcount != gvc_q) begin
      gy_d = (gy_q == GyW'(GRID_Y - 1)) ? '0 : gy_q + 1'b1;
    end
    grid_hit = (gx_d == '0) || (gy_d == '0);
  end

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      gx_q  <= '0;
      gy_q  <= '0;
      gvc_q <= '0;
    end else begin
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      gvc_q <= bus.vcount;
    end
  end
`else
  assign grid_hit = 1'b0;
`endif

  logic [RD_LAT:0] valid_q, grid_q;
  logic            rden_q;
  rgb565_t         pix_d, pix_q;

  // Lowest channel index wins; loop runs high-to-low so the last hit is the winner.
  always_comb begin
    pix_d = BG_COLOR;
    if (grid_q[RD_LAT]) begin
      pix_d = GRID_COLOR;
    end
    for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
      if (bus.data_in[i] && bus.ch_en[i]) begin
        pix_d = ch_color(unsigned'(i));
      end
    end
    if (!valid_q[RD_LAT]) begin
      pix_d = BLACK;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      valid_q <= '0;
      grid_q  <= '0;
      rden_q  <= 1'b0;
      pix_q   <= BLACK;
    end else begin
      valid_q <= {valid_q[RD_LAT-1:0], in_range};
      grid_q  <= {grid_q[RD_LAT-1:0], grid_hit & in_range};
      rden_q  <= in_range;
      pix_q   <= pix_d;
    end
  end

  assign bus.addr         = addr;
  assign bus.rden         = rden_q;
  assign bus.display_data = pix_q;

endmodule

// File: tb/tb_tft_wave_render.sv
// Self-checking bench: RD_LAT=2 and RD_LAT=4 renderers driven in lockstep, frame-buffer models per DUT.
module tb_tft_wave_render;

  localparam int HA = 800;
  localparam int VA = 480;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [10:0] hc, vc;
  logic [1:0] chen;
  logic       oven;
  logic [1:0] ovv;

  always #5 clk = ~clk;

  tft_wave_render_if #(.CH_NUM(2)) bus2 ();
  tft_wave_render_if #(.CH_NUM(2)) bus4 ();

  function automatic logic [1:0] fb(input logic [18:0] a);
    logic [18:0] t;
    t = a ^ (a >> 3) ^ (a >> 9);
    return t[1:0];
  endfunction

  logic [1:0] p2 [2];
  logic [1:0] p4 [4];

  always @(posedge clk) begin
    p2[0] <= bus2.rden ? fb(bus2.addr) : 2'b00;
    p2[1] <= p2[0];
    p4[0] <= bus4.rden ? fb(bus4.addr) : 2'b00;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end

  assign bus2.tft_req = req;
  assign bus2.hcount  = hc;
  assign bus2.vcount  = vc;
  assign bus2.ch_en   = chen;
  assign bus2.data_in = oven ? ovv : p2[1];
  assign bus4.tft_req = req;
  assign bus4.hcount  = hc;
  assign bus4.vcount  = vc;
  assign bus4.ch_en   = chen;
  assign bus4.data_in = oven ? ovv : p4[3];

  tft_wave_render #(
    .H_ACTIVE(800), .V_ACTIVE(480), .CH_NUM(2), .RD_LAT(2), .GRID_X(50), .GRID_Y(48)
  ) dut2 (
    .clk_vga (clk),
    .rst_n   (rst_n),
    .bus     (bus2.slave)
  );

  tft_wave_render #(
    .H_ACTIVE(800), .V_ACTIVE(480), .CH_NUM(2), .RD_LAT(4), .GRID_X(50), .GRID_Y(48)
  ) dut4 (
    .clk_vga (clk),
    .rst_n   (rst_n),
    .bus     (bus4.slave)
  );

  // Per-edge record of what was applied, indexed by edge number modulo 32.
  logic        r_inr  [32];
  logic        r_grid [32];
  logic [18:0] r_addr [32];
  logic [18:0] r_ea   [32];
  logic [1:0]  r_chen [32];
  logic        r_oven [32];
  logic [1:0]  r_ovv  [32];

  int          ecnt;
  int          n_vec;
  int          n_err;
  bit          mon_en;
  int          hrun, vrun, pv;
  logic [18:0] ea_hold;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  function automatic logic [15:0] model_pix(input logic inr, input logic grid,
                                            input logic [1:0] d, input logic [1:0] c);
    if (!inr) return 16'h0000;
    if (d[0] && c[0]) return 16'hFFE0;
    if (d[1] && c[1]) return 16'h07FF;
    return grid ? 16'h4208 : 16'h0000;
  endfunction

  function automatic logic [15:0] sel(input logic [15:0] pg, input logic [15:0] pn);
`ifdef TFT_WAVE_GRID_EN
    return pg;
`else
    return pn;
`endif
  endfunction

  task automatic check_pix(input string nm, input int m, input int lat, input logic [15:0] act);
    int n, k, kn;
    logic [1:0] d;
    n = m - lat - 1;
    if (n >= 0) begin
      k  = m & 31;
      kn = n & 31;
      d  = r_oven[k] ? r_ovv[k] : fb(r_addr[kn]);
      cmp(nm, {16'd0, act}, {16'd0, model_pix(r_inr[kn], r_grid[kn], d, r_chen[k])});
    end
  endtask

  task automatic check_cycle(input int m);
    int k;
    k = m & 31;
    cmp("rden2", {31'd0, bus2.rden}, {31'd0, r_inr[k]});
    cmp("rden4", {31'd0, bus4.rden}, {31'd0, r_inr[k]});
    cmp("addr2", {13'd0, bus2.addr}, {13'd0, r_ea[k]});
    cmp("addr4", {13'd0, bus4.addr}, {13'd0, r_ea[k]});
    check_pix("pix2", m, 2, bus2.display_data);
    check_pix("pix4", m, 4, bus4.display_data);
  endtask

  // One clock: present inputs, record the expectation, then check after the edge.
  task automatic drive(input logic rq, input int h, input int v, input logic [1:0] c,
                       input logic rst);
    int   k;
    logic inr;
    logic g;
    k     = ecnt & 31;
    req   = rq;
    hc    = 11'(h);
    vc    = 11'(v);
    chen  = c;
    rst_n = !rst;
    inr   = !rst && rq && (h < HA) && (v < VA);
    g     = 1'b0;
    if (rst) begin
      for (int i = 0; i < 32; i++) r_inr[i] = 1'b0;
      hrun    = 0;
      vrun    = 0;
      pv      = 0;
      ea_hold = '0;
    end else begin
      hrun = (h == 0) ? 0 : (hrun + 1) % 50;
      if (v == 0) vrun = 0;
      else if (v != pv) vrun = (vrun + 1) % 48;
      pv = v;
      if (inr) ea_hold = 19'(h + HA * v);
`ifdef TFT_WAVE_GRID_EN
      g = (hrun == 0) || (vrun == 0);
`endif
    end
    r_inr[k]  = inr;
    r_grid[k] = g;
    r_addr[k] = 19'(h + HA * v);
    r_ea[k]   = ea_hold;
    r_chen[k] = c;
    r_oven[k] = oven;
    r_ovv[k]  = ovv;
    @(negedge clk);
    if (mon_en) check_cycle(ecnt);
    ecnt++;
  endtask

  typedef struct {
    logic        rq;
    int          h;
    int          v;
    logic [1:0]  chen;
    logic [1:0]  dat;
    logic        rden;
    logic [18:0] addr;
    logic [15:0] pg;
    logic [15:0] pn;
  } vec_t;

  vec_t tbl [13];

  task automatic run_vec(input int idx, input vec_t t);
    logic [15:0] ep;
    ep   = sel(t.pg, t.pn);
    oven = 1'b1;
    ovv  = t.dat;
    drive(1'b0, 0, 0, t.chen, 1'b0);
    for (int vv = 1; vv <= t.v; vv++) drive(1'b0, 0, vv, t.chen, 1'b0);
    for (int hh = 1; hh < t.h; hh++) drive(1'b0, hh, t.v, t.chen, 1'b0);
    drive(t.rq, t.h, t.v, t.chen, 1'b0);
    cmp($sformatf("vec%0d rden2", idx), {31'd0, bus2.rden}, {31'd0, t.rden});
    cmp($sformatf("vec%0d rden4", idx), {31'd0, bus4.rden}, {31'd0, t.rden});
    if (t.rden) begin
      cmp($sformatf("vec%0d addr2", idx), {13'd0, bus2.addr}, {13'd0, t.addr});
      cmp($sformatf("vec%0d addr4", idx), {13'd0, bus4.addr}, {13'd0, t.addr});
    end
    for (int i = 0; i < 3; i++) drive(1'b0, t.h, t.v, t.chen, 1'b0);
    cmp($sformatf("vec%0d pix2", idx), {16'd0, bus2.display_data}, {16'd0, ep});
    for (int i = 0; i < 2; i++) drive(1'b0, t.h, t.v, t.chen, 1'b0);
    cmp($sformatf("vec%0d pix4", idx), {16'd0, bus4.display_data}, {16'd0, ep});
  endtask

  initial begin
    int hs [6];
    n_vec  = 0;
    n_err  = 0;
    ecnt   = 0;
    mon_en = 1'b0;
    oven   = 1'b0;
    ovv    = 2'b00;

    //            rq    h    v   chen   dat   rden  addr     grid     nogrid
    tbl[0]  = '{1'b1,   0,   0, 2'b11, 2'b11, 1'b1, 19'd0,      16'hFFE0, 16'hFFE0};
    tbl[1]  = '{1'b1,   0,   0, 2'b10, 2'b11, 1'b1, 19'd0,      16'h07FF, 16'h07FF};
    tbl[2]  = '{1'b1,   0,   0, 2'b00, 2'b11, 1'b1, 19'd0,      16'h4208, 16'h0000};
    tbl[3]  = '{1'b1,  50,   1, 2'b11, 2'b00, 1'b1, 19'd850,    16'h4208, 16'h0000};
    tbl[4]  = '{1'b1,  51,   1, 2'b11, 2'b00, 1'b1, 19'd851,    16'h0000, 16'h0000};
    tbl[5]  = '{1'b1,   3,  48, 2'b11, 2'b00, 1'b1, 19'd38403,  16'h4208, 16'h0000};
    tbl[6]  = '{1'b1, 800,   5, 2'b11, 2'b11, 1'b0, 19'd0,      16'h0000, 16'h0000};
    tbl[7]  = '{1'b1,  10, 480, 2'b11, 2'b11, 1'b0, 19'd0,      16'h0000, 16'h0000};
    tbl[8]  = '{1'b0,  10,   5, 2'b11, 2'b11, 1'b0, 19'd0,      16'h0000, 16'h0000};
    tbl[9]  = '{1'b1, 799, 479, 2'b11, 2'b01, 1'b1, 19'd383999, 16'hFFE0, 16'hFFE0};
    tbl[10] = '{1'b1,   5,   7, 2'b11, 2'b10, 1'b1, 19'd5605,   16'h07FF, 16'h07FF};
    tbl[11] = '{1'b1, 120,  96, 2'b11, 2'b00, 1'b1, 19'd76920,  16'h4208, 16'h0000};
    tbl[12] = '{1'b1,  25,   3, 2'b01, 2'b10, 1'b1, 19'd2425,   16'h0000, 16'h0000};

    @(negedge clk);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 0, 2'b00, 1'b1);
    cmp("reset rden2", {31'd0, bus2.rden}, 32'd0);
    cmp("reset addr2", {13'd0, bus2.addr}, 32'd0);
    cmp("reset pix2", {16'd0, bus2.display_data}, 32'd0);
    cmp("reset pix4", {16'd0, bus4.display_data}, 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);

    // Sparse full-frame scan: every line visited, a few columns each.
    oven = 1'b0;
    for (int v = 0; v < VA; v++) begin
      hs    = '{0, 1, 0, 798, 799, 800};
      hs[2] = int'($urandom_range(2, 797));
      for (int j = 0; j < 6; j++) begin
        drive(1'b1, hs[j], v, 2'($urandom), 1'b0);
        if (v == VA - 1 && hs[j] == 799) begin
          cmp("last addr2", {13'd0, bus2.addr}, 32'd383999);
          cmp("last addr4", {13'd0, bus4.addr}, 32'd383999);
        end
      end
    end
    drive(1'b1, 0, 0, 2'($urandom), 1'b0);
    cmp("wrap addr2", {13'd0, bus2.addr}, 32'd0);
    cmp("wrap addr4", {13'd0, bus4.addr}, 32'd0);

    // Dense scan with random request gaps and per-cycle channel enables.
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 830; h++) begin
        drive($urandom_range(0, 7) != 0, h, v, 2'($urandom), 1'b0);
      end
    end

    // Reset mid-line, then the driver restarts its frame.
    for (int v = 0; v < 3; v++) begin
      for (int h = 0; h < ((v == 2) ? 300 : 400); h++) begin
        drive($urandom_range(0, 3) != 0, h, v, 2'($urandom), 1'b0);
      end
    end
    drive(1'b1, 300, 2, 2'b11, 1'b1);
    cmp("midrst rden2", {31'd0, bus2.rden}, 32'd0);
    cmp("midrst addr2", {13'd0, bus2.addr}, 32'd0);
    cmp("midrst pix2", {16'd0, bus2.display_data}, 32'd0);
    cmp("midrst rden4", {31'd0, bus4.rden}, 32'd0);
    cmp("midrst addr4", {13'd0, bus4.addr}, 32'd0);
    cmp("midrst pix4", {16'd0, bus4.display_data}, 32'd0);
    for (int v = 0; v < 2; v++) begin
      for (int h = 0; h < 200; h++) begin
        drive($urandom_range(0, 7) != 0, h, v, 2'($urandom), 1'b0);
      end
    end

    for (int i = 0; i < 8; i++) drive(1'b0, 0, 0, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
